scale_controller: RTL and testbench
===================================

// Module: scale_controller
// PURPOSE
//  Owns the camera display-scale setting and generates frame-buffer read addresses for it.
//  A button press cycles the requested scale 1x -> 2x -> 8/3x -> 1x.
//  The request is committed only at frame start, so a frame never mixes two scales.
//  Maps the 11-bit hcount / 10-bit vcount raster onto the 240x320 portrait frame buffer.
//  Sits between the video timing generator and the frame-buffer read port;
//  scale_out feeds the window-select stage.
// PARAMETERS
//  FB_WIDTH    240  frame-buffer pixels per row
//  FB_HEIGHT   320  frame-buffer rows
//  ADDR_WIDTH  17   frame-buffer address width (FB_WIDTH*FB_HEIGHT = 76800 <= 2^17)
// PORTS
//  clk_in         in   1   pixel clock; single clock domain
//  rst_in         in   1   synchronous, active-high reset
//  btn_in         in   1   debounced, synchronised scale button (level)
//  hcount_in      in   11  raster x
//  vcount_in      in   10  raster y
//  scale_out      out  2   committed scale: 0=1x, 1=2x, 2=8/3x (3 never driven)
//  pending_out    out  1   1 when requested scale != committed scale
//  addr_out       out  17  frame-buffer read address, 2-cycle latency
//  in_window_out  out  1   addr_out is a valid in-image pixel, aligned with addr_out
// BEHAVIOUR
//  Reset values:
//   - scale_out=0, pending register=0, pending_out=0, addr_out=0, in_window_out=0.
//   - Button history register = 1, so a button held through reset gives no increment.
//   - All pipeline registers are cleared. Reset asserted mid-frame takes effect on the next edge.
//  Button handling:
//   - Rising edge = btn_in==1 && btn_prev==0.
//   - On a rising edge: req <= (req==2) ? 0 : req+1. Each rising edge advances req exactly once.
//  Commit:
//   - frame_start = (hcount_in==0 && vcount_in==0).
//   - On frame_start: scale_out <= req, using req's value before any same-cycle increment.
//   - A rising edge on the frame_start cycle still updates req; that new request commits next frame.
//   - pending_out = (req != scale_out), registered behaviour; combinational compare of regs.
//  Address pipeline:
//   - eff_scale = frame_start ? req : scale_out.
//     Pixel (0,0) of a new frame already uses the new scale.
//   - Stage 1 registers x_s(8b), y_s(9b) and win from eff_scale:
//       0: x=h,          y=v,          win = h<240 && v<320
//       1: x=h>>1,       y=v>>1,       win = h<480 && v<640
//       2: x=(h*3)>>3,   y=(v*3)>>3,   win = h<640 && v<853
//     Products are computed at 13/12-bit width; no truncation before the shift.
//   - Stage 2: addr_out <= win ? y_s*FB_WIDTH + x_s : 0; in_window_out <= win.
//   - Latency: hcount/vcount sampled at edge N -> addr_out/in_window_out valid after edge N+2.
//   - Maximum address in every scale is 76799. It never exceeds FB_WIDTH*FB_HEIGHT-1.
//   - Out-of-window pixels always give addr_out=0 and in_window_out=0.
// TESTING
//  - Reset asserted 3 cycles, btn_in=1 held
//      -> scale_out=0, pending_out=0, addr_out=0, in_window_out=0.
//      -> no increment after release.
//  - Scale 0, (h,v)=(239,319) -> 2 cycles later addr_out=76799, in_window_out=1.
//  - Scale 0, (240,0) -> addr_out=0, in_window_out=0.
//  - One press at (100,50) -> pending_out=1, scale_out stays 0.
//      -> at (0,0) scale_out=1, pending_out=0.
//      -> (101,3) then gives addr_out=290.
//  - Scale 2, (639,852) -> addr_out=76799, win=1.
//  - Scale 2, (8,8) -> addr_out=723.
//  - Scale 2, (640,0) -> win=0.
//  - Three presses within one frame -> req wraps to 0, pending_out=0.
//      -> scale_out unchanged at next frame start.
//  - Press coinciding with (0,0) while req=1, scale_out=0
//      -> scale_out=1 and req=2, pending_out=1.
//      -> scale_out=2 at the following frame start.

Source files
------------

// File: rtl/scale_controller.sv
// rtl/scale_controller.sv - display-scale register with frame-synchronous commit and frame-buffer address pipeline
module scale_controller #(
    parameter int FB_WIDTH   = 240,
    parameter int FB_HEIGHT  = 320,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  btn_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    output logic [1:0]            scale_out,
    output logic                  pending_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  in_window_out
);

    localparam logic [1:0] SCALE_1X  = 2'd0;
    localparam logic [1:0] SCALE_2X  = 2'd1;
    localparam logic [1:0] SCALE_8_3 = 2'd2;

    localparam logic [10:0] WIN0_H = 11'(FB_WIDTH);
    localparam logic [9:0]  WIN0_V = 10'(FB_HEIGHT);
    localparam logic [10:0] WIN1_H = 11'(FB_WIDTH * 2);
    localparam logic [9:0]  WIN1_V = 10'(FB_HEIGHT * 2);
    localparam logic [10:0] WIN2_H = 11'(FB_WIDTH * 8 / 3);
    localparam logic [9:0]  WIN2_V = 10'(FB_HEIGHT * 8 / 3);

    logic        btn_prev;
    logic [1:0]  req;
    logic        frame_start;
    logic        btn_rise;
    logic [1:0]  eff_scale;

    logic [12:0] h3;
    logic [11:0] v3;
    logic [7:0]  x_next;
    logic [8:0]  y_next;
    logic        win_next;

    logic [7:0]  x_s;
    logic [8:0]  y_s;
    logic        win_s;

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign btn_rise    = btn_in && !btn_prev;
    // The frame's first pixel must already see the scale being committed on this cycle.
    assign eff_scale   = frame_start ? req : scale_out;
    assign pending_out = (req != scale_out);

    assign h3 = {2'b00, hcount_in} * 13'd3;
    assign v3 = {2'b00, vcount_in} * 12'd3;

    always_comb begin
        x_next   = hcount_in[7:0];
        y_next   = vcount_in[8:0];
        win_next = 1'b0;
        case (eff_scale)
            SCALE_1X: begin
                x_next   = hcount_in[7:0];
                y_next   = vcount_in[8:0];
                win_next = (hcount_in < WIN0_H) && (vcount_in < WIN0_V);
            end
            SCALE_2X: begin
                x_next   = hcount_in[8:1];
                y_next   = vcount_in[9:1];
                win_next = (hcount_in < WIN1_H) && (vcount_in < WIN1_V);
            end
            SCALE_8_3: begin
                x_next   = h3[10:3];
                y_next   = v3[11:3];
                win_next = (hcount_in < WIN2_H) && (vcount_in < WIN2_V);
            end
            default: begin
                x_next   = 8'd0;
                y_next   = 9'd0;
                win_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // History starts high so a button held through reset is not seen as a press.
            btn_prev  <= 1'b1;
            req       <= SCALE_1X;
            scale_out <= SCALE_1X;
        end else begin
            btn_prev <= btn_in;
            if (btn_rise)
                req <= (req == SCALE_8_3) ? SCALE_1X : req + 2'd1;
            if (frame_start)
                scale_out <= req;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_s           <= 8'd0;
            y_s           <= 9'd0;
            win_s         <= 1'b0;
            addr_out      <= '0;
            in_window_out <= 1'b0;
        end else begin
            x_s           <= x_next;
            y_s           <= y_next;
            win_s         <= win_next;
            addr_out      <= win_s ? (ADDR_WIDTH'(y_s) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(x_s))
                                   : '0;
            in_window_out <= win_s;
        end
    end

endmodule

// File: tb/tb_scale_controller.sv
// tb/tb_scale_controller.sv - directed self-checking bench for scale_controller
module tb_scale_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        btn_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  scale_out;
    logic        pending_out;
    logic [16:0] addr_out;
    logic        in_window_out;

    int passed = 0;
    int total  = 0;

    scale_controller dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .btn_in        (btn_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .scale_out     (scale_out),
        .pending_out   (pending_out),
        .addr_out      (addr_out),
        .in_window_out (in_window_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_pos(input logic [10:0] h, input logic [9:0] v);
        hcount_in = h;
        vcount_in = v;
    endtask

    // Hold a coordinate long enough for it to reach addr_out.
    task automatic hold_pos(input logic [10:0] h, input logic [9:0] v);
        set_pos(h, v);
        step();
        step();
        step();
    endtask

    task automatic press();
        btn_in = 1'b1;
        step();
        btn_in = 1'b0;
        step();
    endtask

    task automatic frame_start();
        set_pos(11'd0, 10'd0);
        step();
        set_pos(11'd1000, 10'd1000);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        btn_in = 1'b1;
        set_pos(11'd1000, 10'd1000);
        step();
        step();
        step();
        total++; if (scale_out !== 2'd0) $display("FAIL reset_scale: got %0d expected 0", scale_out); else passed++;
        total++; if (pending_out !== 1'b0) $display("FAIL reset_pending: got %0d expected 0", pending_out); else passed++;
        total++; if (addr_out !== 17'd0) $display("FAIL reset_addr: got %0d expected 0", addr_out); else passed++;
        total++; if (in_window_out !== 1'b0) $display("FAIL reset_win: got %0d expected 0", in_window_out); else passed++;
        rst_in = 1'b0;
        step();
        btn_in = 1'b0;
        step();
        total++; if (pending_out !== 1'b0) $display("FAIL reset_held_btn_pending: got %0d expected 0", pending_out); else passed++;
        frame_start();
        step();
        total++; if (scale_out !== 2'd0) $display("FAIL reset_held_btn_scale: got %0d expected 0", scale_out); else passed++;
    endtask

    task automatic test_scale0();
        hold_pos(11'd239, 10'd319);
        total++; if (addr_out !== 17'd76799) $display("FAIL s0_max_addr: got %0d expected 76799", addr_out); else passed++;
        total++; if (in_window_out !== 1'b1) $display("FAIL s0_max_win: got %0d expected 1", in_window_out); else passed++;
        hold_pos(11'd240, 10'd0);
        total++; if (addr_out !== 17'd0) $display("FAIL s0_edge_addr: got %0d expected 0", addr_out); else passed++;
        total++; if (in_window_out !== 1'b0) $display("FAIL s0_edge_win: got %0d expected 0", in_window_out); else passed++;
        hold_pos(11'd10, 10'd2);
        total++; if (addr_out !== 17'd490) $display("FAIL s0_mid_addr: got %0d expected 490", addr_out); else passed++;
    endtask

    task automatic test_press_commit();
        set_pos(11'd100, 10'd50);
        press();
        total++; if (pending_out !== 1'b1) $display("FAIL press_pending: got %0d expected 1", pending_out); else passed++;
        total++; if (scale_out !== 2'd0) $display("FAIL press_scale_held: got %0d expected 0", scale_out); else passed++;
        frame_start();
        #1;
        total++; if (scale_out !== 2'd1) $display("FAIL commit_scale: got %0d expected 1", scale_out); else passed++;
        total++; if (pending_out !== 1'b0) $display("FAIL commit_pending: got %0d expected 0", pending_out); else passed++;
        hold_pos(11'd101, 10'd3);
        total++; if (addr_out !== 17'd290) $display("FAIL s1_addr: got %0d expected 290", addr_out); else passed++;
        total++; if (in_window_out !== 1'b1) $display("FAIL s1_win: got %0d expected 1", in_window_out); else passed++;
        hold_pos(11'd480, 10'd0);
        total++; if (in_window_out !== 1'b0) $display("FAIL s1_edge_win: got %0d expected 0", in_window_out); else passed++;
    endtask

    task automatic test_scale2();
        set_pos(11'd1000, 10'd1000);
        press();
        frame_start();
        #1;
        total++; if (scale_out !== 2'd2) $display("FAIL s2_commit: got %0d expected 2", scale_out); else passed++;
        hold_pos(11'd639, 10'd852);
        total++; if (addr_out !== 17'd76799) $display("FAIL s2_max_addr: got %0d expected 76799", addr_out); else passed++;
        total++; if (in_window_out !== 1'b1) $display("FAIL s2_max_win: got %0d expected 1", in_window_out); else passed++;
        hold_pos(11'd8, 10'd8);
        total++; if (addr_out !== 17'd723) $display("FAIL s2_addr_8_8: got %0d expected 723", addr_out); else passed++;
        hold_pos(11'd640, 10'd0);
        total++; if (in_window_out !== 1'b0) $display("FAIL s2_edge_h_win: got %0d expected 0", in_window_out); else passed++;
        total++; if (addr_out !== 17'd0) $display("FAIL s2_edge_h_addr: got %0d expected 0", addr_out); else passed++;
        hold_pos(11'd0, 10'd853);
        total++; if (in_window_out !== 1'b0) $display("FAIL s2_edge_v_win: got %0d expected 0", in_window_out); else passed++;
    endtask

    task automatic test_wrap();
        set_pos(11'd1000, 10'd1000);
        press();
        press();
        press();
        total++; if (pending_out !== 1'b0) $display("FAIL wrap_pending: got %0d expected 0", pending_out); else passed++;
        frame_start();
        #1;
        total++; if (scale_out !== 2'd2) $display("FAIL wrap_scale: got %0d expected 2", scale_out); else passed++;
    endtask

    task automatic test_press_at_frame_start();
        set_pos(11'd1000, 10'd1000);
        press();
        frame_start();
        #1;
        total++; if (scale_out !== 2'd0) $display("FAIL fs_setup_scale: got %0d expected 0", scale_out); else passed++;
        press();
        total++; if (pending_out !== 1'b1) $display("FAIL fs_setup_pending: got %0d expected 1", pending_out); else passed++;
        set_pos(11'd0, 10'd0);
        btn_in = 1'b1;
        step();
        total++; if (scale_out !== 2'd1) $display("FAIL fs_press_scale: got %0d expected 1", scale_out); else passed++;
        total++; if (pending_out !== 1'b1) $display("FAIL fs_press_pending: got %0d expected 1", pending_out); else passed++;
        btn_in = 1'b0;
        set_pos(11'd1000, 10'd1000);
        step();
        frame_start();
        #1;
        total++; if (scale_out !== 2'd2) $display("FAIL fs_next_scale: got %0d expected 2", scale_out); else passed++;
        total++; if (pending_out !== 1'b0) $display("FAIL fs_next_pending: got %0d expected 0", pending_out); else passed++;
    endtask

    task automatic test_reset_midframe();
        hold_pos(11'd8, 10'd8);
        rst_in = 1'b1;
        step();
        total++; if (scale_out !== 2'd0) $display("FAIL midrst_scale: got %0d expected 0", scale_out); else passed++;
        total++; if (in_window_out !== 1'b0) $display("FAIL midrst_win: got %0d expected 0", in_window_out); else passed++;
        rst_in = 1'b0;
        step();
    endtask

    initial begin
        rst_in = 1'b1;
        btn_in = 1'b0;
        hcount_in = 11'd1000;
        vcount_in = 10'd1000;
        test_reset();
        test_scale0();
        test_press_commit();
        test_scale2();
        test_wrap();
        test_press_at_frame_start();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
